// File: rtl/sevenseg_pkg.sv
// Shared types and hex glyph constants for the multiplexed seven-segment driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied at the pins.
package sevenseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h00;

   localparam seg_t GLYPH_0 = 7'h3F;
   localparam seg_t GLYPH_1 = 7'h06;
   localparam seg_t GLYPH_2 = 7'h5B;
   localparam seg_t GLYPH_3 = 7'h4F;
   localparam seg_t GLYPH_4 = 7'h66;
   localparam seg_t GLYPH_5 = 7'h6D;
   localparam seg_t GLYPH_6 = 7'h7D;
   localparam seg_t GLYPH_7 = 7'h07;
   localparam seg_t GLYPH_8 = 7'h7F;
   localparam seg_t GLYPH_9 = 7'h6F;
   localparam seg_t GLYPH_A = 7'h77;
   localparam seg_t GLYPH_B = 7'h7C;
   localparam seg_t GLYPH_C = 7'h39;
   localparam seg_t GLYPH_D = 7'h5E;
   localparam seg_t GLYPH_E = 7'h79;
   localparam seg_t GLYPH_F = 7'h71;

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational hex nibble to active-high segment pattern; a dark digit lights nothing.
module sevenseg_decoder
   import sevenseg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dark,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!dark) begin
         case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            default: seg = GLYPH_F;
         endcase
      end
   end

endmodule

// File: rtl/sevenseg_mux_n.sv
// N-digit time-multiplexed hex display driver with dead time, blanking,
// leading-zero suppression and frame-synchronous (tear-free) display update.
module sevenseg_mux_n
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 4096,
   parameter int DEAD_CYCLES    = 64,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4*NUM_DIGITS-1:0]       digits,
   input  logic [NUM_DIGITS-1:0]         blank,
   input  logic                          lz_en,
   input  logic                          load,
   output logic [NUM_DIGITS-1:0]         power,
   output logic [6:0]                    segs,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_tick
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(REFRESH_DIV);

   // XOR masks: an inactive pin level doubles as the polarity inversion mask
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
   localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};

   logic                    run;
   logic [CNT_W-1:0]        slot_cnt;
   logic [CNT_W-1:0]        slot_nxt;
   logic [IDX_W-1:0]        idx_nxt;
   logic                    frame_start;
   logic [4*NUM_DIGITS-1:0] pend_digits;
   logic [NUM_DIGITS-1:0]   pend_blank;
   logic [4*NUM_DIGITS-1:0] disp_digits;
   logic [NUM_DIGITS-1:0]   disp_blank;
   logic [NUM_DIGITS-1:0]   dark;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   an_sel;
   seg_t                    seg_hi;

   // The first cycle out of reset holds position (0,0) so it is a real slot-0 cycle
   always_comb begin
      slot_nxt = slot_cnt;
      idx_nxt  = digit_idx;
      if (run) begin
         if (slot_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            slot_nxt = '0;
            idx_nxt  = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
         end else begin
            slot_nxt = slot_cnt + CNT_W'(1);
         end
      end
      frame_start = (slot_nxt == '0) && (idx_nxt == '0);
   end

   // Leading zeros are counted from the most significant digit down; digit 0 always shows
   always_comb begin
      dark     = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (disp_digits[4*i +: 4] == 4'h0);
         dark[i]  = disp_blank[i] | (lz_en & zero_run & (i != 0));
      end
   end

   sevenseg_decoder u_dec (
      .nibble (disp_digits[4*digit_idx +: 4]),
      .dark   (dark[digit_idx]),
      .seg    (seg_hi)
   );

   always_comb begin
      an_sel = '0;
      an_sel[digit_idx] = 1'b1;
   end

   // Outputs only move on slot start (all off) and at the end of dead time (glyph on)
   always_ff @(posedge clk) begin
      if (reset) begin
         run         <= 1'b0;
         slot_cnt    <= '0;
         digit_idx   <= '0;
         pend_digits <= '0;
         pend_blank  <= '0;
         disp_digits <= '0;
         disp_blank  <= '0;
         power       <= AN_OFF;
         segs        <= SEG_OFF;
         frame_tick  <= 1'b0;
      end else begin
         run        <= 1'b1;
         slot_cnt   <= slot_nxt;
         digit_idx  <= idx_nxt;
         frame_tick <= frame_start;
         if (load) begin
            pend_digits <= digits;
            pend_blank  <= blank;
         end
         if (frame_start) begin
            disp_digits <= load ? digits : pend_digits;
            disp_blank  <= load ? blank  : pend_blank;
         end
         if (slot_nxt == '0) begin
            power <= AN_OFF;
            segs  <= SEG_OFF;
         end else if (slot_nxt == CNT_W'(DEAD_CYCLES)) begin
            power <= an_sel ^ AN_OFF;
            segs  <= seg_hi ^ SEG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// Randomised and directed bench for sevenseg_mux_n against a time-indexed display model.
module tb_sevenseg_mux_n;

   localparam int N    = 4;
   localparam int RD   = 8;
   localparam int DEAD = 2;
   localparam int FR   = N * RD;

   logic        clk;
   logic        reset;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic        lz_en;
   logic        load;
   logic [3:0]  power;
   logic [6:0]  segs;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // model state
   bit          running = 0;
   int          t = 0;
   logic [15:0] m_pd = 0, m_dd = 0;
   logic [3:0]  m_pb = 0, m_db = 0;
   logic [6:0]  m_latch = 7'h7F;
   logic [3:0]  e_pow = 4'hF;
   logic [6:0]  e_seg = 7'h7F;
   logic        e_tick = 0;
   logic [1:0]  e_idx = 0;

   sevenseg_mux_n #(
      .NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .digits(digits), .blank(blank), .lz_en(lz_en),
      .load(load), .power(power), .segs(segs), .digit_idx(digit_idx),
      .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Pin-level segments for digit i of a display word (active-low pins)
   function automatic logic [6:0] model_segs(input logic [15:0] d, input logic [3:0] b,
                                             input logic lz, input int i);
      logic dk;
      logic all0;
      dk = b[i];
      if (lz && i != 0) begin
         all0 = 1'b1;
         for (int j = i; j < N; j++) if (d[4*j +: 4] != 4'h0) all0 = 1'b0;
         if (all0) dk = 1'b1;
      end
      return dk ? 7'h7F : ~glyph(d[4*i +: 4]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Position in the scan is a pure function of cycles elapsed since reset release
   always @(posedge clk) begin
      int slot;
      int idx;
      if (reset) begin
         running = 0; t = 0;
         m_pd = 0; m_pb = 0; m_dd = 0; m_db = 0;
         e_pow = 4'hF; e_seg = 7'h7F; e_tick = 0; e_idx = 0;
      end else begin
         if (running) t++;
         else begin running = 1; t = 0; end
         if (load) begin m_pd = digits; m_pb = blank; end
         if (t % FR == 0) begin m_dd = m_pd; m_db = m_pb; end
         slot = t % RD;
         idx  = (t / RD) % N;
         if (slot == DEAD) m_latch = model_segs(m_dd, m_db, lz_en, idx);
         e_tick = (t % FR == 0);
         e_idx  = idx[1:0];
         e_pow  = (slot < DEAD) ? 4'hF : (4'hF ^ (4'b0001 << idx));
         e_seg  = (slot < DEAD) ? 7'h7F : m_latch;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("power", power, e_pow);
         check("segs", segs, e_seg);
         check("frame_tick", frame_tick, e_tick);
         check("digit_idx", digit_idx, e_idx);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic pulse_load(input logic [15:0] d, input logic [3:0] b);
      digits = d; blank = b; load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic wait_pos(input int di, input int sl);
      bit found = 0;
      for (int k = 0; k < 2 * FR + 2; k++) begin
         cyc();
         if (running && (t % FR) == di * RD + sl) begin
            found = 1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL wait_pos digit %0d slot %0d: position not reached, t=%0d", di, sl, t);
      end
   endtask

   initial begin
      logic [15:0] mask;
      reset = 1'b1; digits = '0; blank = '0; lz_en = 1'b0; load = 1'b0;
      cyc();
      chk_en = 1;
      cyc(); cyc();
      check("rst_power", power, 4'hF);
      check("rst_segs", segs, 7'h7F);
      check("rst_tick", frame_tick, 1'b0);

      reset = 1'b0;
      cyc();
      check("first_tick", frame_tick, 1'b1);
      check("first_power", power, 4'hF);

      pulse_load(16'h12AF, 4'h0);
      wait_pos(0, 0);
      check("a_dead_power", power, 4'hF);
      wait_pos(0, 2);
      check("a_power", power, 4'b1110);
      check("a_segs_F", segs, 7'h0E);
      wait_pos(0, 7);
      check("a_segs_hold", segs, 7'h0E);

      lz_en = 1'b1;
      pulse_load(16'h0050, 4'h0);
      wait_pos(0, 0);
      wait_pos(0, 2); check("lz_d0", segs, 7'h40);
      wait_pos(1, 2); check("lz_d1", segs, 7'h12);
      wait_pos(2, 2); check("lz_d2", segs, 7'h7F); check("lz_d2_pow", power, 4'b1011);
      wait_pos(3, 2); check("lz_d3", segs, 7'h7F);

      pulse_load(16'h0000, 4'h0);
      wait_pos(0, 0);
      wait_pos(0, 2); check("z_d0", segs, 7'h40);
      wait_pos(1, 2); check("z_d1", segs, 7'h7F);

      wait_pos(0, 0);
      wait_pos(1, 0);
      pulse_load(16'h1111, 4'h0);
      wait_pos(2, 0);
      pulse_load(16'h2222, 4'h0);
      wait_pos(3, 2); check("tear_d3", segs, 7'h7F);
      wait_pos(0, 0);
      wait_pos(0, 2); check("last_d0", segs, 7'h24);
      wait_pos(1, 2); check("last_d1", segs, 7'h24);
      wait_pos(3, 2); check("last_d3", segs, 7'h24);

      lz_en = 1'b0;
      pulse_load(16'h8888, 4'b0100);
      wait_pos(0, 0);
      wait_pos(0, 2); check("bl_d0", segs, 7'h00);
      wait_pos(2, 2); check("bl_d2", segs, 7'h7F); check("bl_d2_pow", power, 4'b1011);
      wait_pos(3, 2); check("bl_d3", segs, 7'h00);

      for (int c = 0; c < 1200; c++) begin
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 4))
               0: mask = 16'hFFFF;
               1: mask = 16'h0FFF;
               2: mask = 16'h00FF;
               3: mask = 16'h000F;
               default: mask = 16'h0000;
            endcase
            digits = 16'($urandom) & mask;
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            load   = 1'b1;
         end else begin
            load = 1'b0;
         end
         if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
         cyc();
      end
      load = 1'b0;

      wait_pos(2, 5);
      reset = 1'b1;
      cyc();
      check("mid_rst_power", power, 4'hF);
      check("mid_rst_segs", segs, 7'h7F);
      check("mid_rst_tick", frame_tick, 1'b0);
      check("mid_rst_idx", digit_idx, 2'd0);
      reset = 1'b0;
      lz_en = 1'b0;
      cyc();
      check("restart_tick", frame_tick, 1'b1);
      wait_pos(0, 2); check("clr_d0", segs, 7'h40);
      wait_pos(1, 2); check("clr_d1", segs, 7'h40);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
